// File: rtl/wb_bram_pkg.sv
// Shared types and constants for the Wishbone wait-state BRAM controller.
// Holds the FSM state encoding, default parameters and the address-window decode.
package wb_bram_pkg;

  localparam int unsigned WB_DEPTH_DEF    = 1024;
  localparam logic [31:0] WB_BASE_DEF     = 32'h3800_0000;
  localparam int unsigned WB_WAIT_DEF     = 10;
  localparam int unsigned WB_WAIT_W_DEF   = 4;
  localparam int unsigned WORD_W          = 32;
  localparam int unsigned LANES           = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_ACK    = 3'd3,
    ST_PFETCH = 3'd4
  } state_e;

  // Window hit when every address bit above the word index matches the base.
  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input int unsigned aw);
    logic [31:0] diff_s;
    diff_s = (adr ^ base) >> (aw + 32'd2);
    return (diff_s == 32'd0);
  endfunction

endpackage

// File: rtl/wb_sram_sp.sv
// Single-port 32-bit word RAM with byte-lane write enables and a one-cycle read.
// The read register keeps its last value whenever the RAM is not enabled.
module wb_sram_sp
  import wb_bram_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic [LANES-1:0]         we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WORD_W-1:0]        din,
  output logic [WORD_W-1:0]        dout
);

  logic [WORD_W-1:0] mem_r [DEPTH];

  // Storage array: lane-masked write, read-before-write data into the output register.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < LANES; i++) begin
        if (we[i]) begin
          mem_r[addr][8*i +: 8] <= din[8*i +: 8];
        end
      end
      dout <= mem_r[addr];
    end
  end

endmodule

// File: rtl/wb_bram_wait_ctrl.sv
// Wishbone classic slave in front of a word RAM: programmable wait states, byte-lane
// writes, window decode with out-of-range pulse, abort on request drop and a one-word read prefetch.
module wb_bram_wait_ctrl
  import wb_bram_pkg::*;
#(
  parameter int unsigned DEPTH     = WB_DEPTH_DEF,
  parameter logic [31:0] BASE_ADDR = WB_BASE_DEF,
  parameter int unsigned DEF_WAIT  = WB_WAIT_DEF,
  parameter int unsigned WAIT_W    = WB_WAIT_W_DEF,
  parameter bit          PREFETCH  = 1'b1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rstn_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic [31:0]       wbs_adr_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              cfg_ovr_i,
  input  logic [WAIT_W-1:0] cfg_wait_i,
  output logic              irq_oor_o
);

  localparam int unsigned       AW         = $clog2(DEPTH);
  localparam logic [WAIT_W-1:0] DEF_WAIT_V = WAIT_W'(DEF_WAIT);
  localparam logic [AW-1:0]     LAST_IDX   = AW'(DEPTH - 1);

  state_e            state_r, state_nxt_s;
  logic              req_s, win_s, hit_s;
  logic [AW-1:0]     idx_s, pf_nxt_idx_s;
  logic [WAIT_W-1:0] wait_sel_s;
  logic [31:0]       hit_data_s;

  logic [WAIT_W-1:0] cnt_r, wait_r;
  logic [AW-1:0]     idx_r;
  logic              we_r;
  logic [3:0]        sel_r;
  logic [31:0]       wdat_r;

  logic              pf_valid_r, pf_load_r;
  logic [AW-1:0]     pf_idx_r;
  logic [31:0]       pf_data_r;

  logic              ack_r, irq_r, dat_ram_r;
  logic [31:0]       dat_r;

  logic              ram_en_s;
  logic [3:0]        ram_we_s;
  logic [AW-1:0]     ram_addr_s;
  logic [31:0]       ram_dout_s;

  assign req_s         = wbs_stb_i & wbs_cyc_i;
  assign win_s         = in_window(wbs_adr_i, BASE_ADDR, AW);
  assign idx_s         = wbs_adr_i[AW+1:2];
  assign pf_nxt_idx_s  = idx_r + AW'(1'b1);
  assign wait_sel_s    = cfg_ovr_i ? cfg_wait_i : DEF_WAIT_V;
  assign hit_s         = PREFETCH & pf_valid_r & (idx_s == pf_idx_r);
  // Right after a prefetch the RAM output register still holds the fetched word.
  assign hit_data_s    = pf_load_r ? ram_dout_s : pf_data_r;

  // Next-state decode for the transfer sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!req_s) begin
          state_nxt_s = ST_IDLE;
        end else if (!win_s) begin
          state_nxt_s = ST_ACK;
        end else if (!wbs_we_i && hit_s) begin
          state_nxt_s = ST_ACK;
        end else if (wait_sel_s == {WAIT_W{1'b0}}) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!req_s) begin
          state_nxt_s = ST_IDLE;
        end else if (cnt_r == wait_r) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_ACCESS: begin
        if (req_s) begin
          state_nxt_s = ST_ACK;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (PREFETCH && dat_ram_r && (idx_r != LAST_IDX)) begin
          state_nxt_s = ST_PFETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PFETCH: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // RAM port: one enabled cycle per access or prefetch, address from request or prefetch index.
  always_comb begin
    ram_en_s   = 1'b0;
    ram_we_s   = 4'h0;
    ram_addr_s = idx_r;
    if (state_r == ST_ACCESS) begin
      ram_en_s = 1'b1;
      ram_we_s = sel_r & {4{we_r}};
    end else if (state_r == ST_PFETCH) begin
      ram_en_s   = 1'b1;
      ram_addr_s = pf_nxt_idx_s;
    end else begin
      ram_en_s = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Request capture and wait counter; the wait count is frozen when the transfer starts.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      cnt_r  <= {WAIT_W{1'b0}};
      wait_r <= {WAIT_W{1'b0}};
      idx_r  <= {AW{1'b0}};
      we_r   <= 1'b0;
      sel_r  <= 4'h0;
      wdat_r <= 32'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s && win_s && !(!wbs_we_i && hit_s)) begin
            idx_r  <= idx_s;
            we_r   <= wbs_we_i;
            sel_r  <= wbs_sel_i;
            wdat_r <= wbs_dat_i;
            wait_r <= wait_sel_s;
            cnt_r  <= WAIT_W'(1'b1);
          end
        end
        ST_WAIT: begin
          if (state_nxt_s == ST_WAIT) begin
            cnt_r <= cnt_r + WAIT_W'(1'b1);
          end else begin
            cnt_r <= {WAIT_W{1'b0}};
          end
        end
        default: begin
          cnt_r <= {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // Prefetch buffer; any write to the buffered index invalidates it in the same cycle.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      pf_valid_r <= 1'b0;
      pf_load_r  <= 1'b0;
      pf_idx_r   <= {AW{1'b0}};
      pf_data_r  <= 32'h0;
    end else begin
      pf_load_r <= (state_r == ST_PFETCH);
      if (pf_load_r) begin
        pf_data_r <= ram_dout_s;
      end
      if (state_r == ST_PFETCH) begin
        pf_valid_r <= 1'b1;
        pf_idx_r   <= pf_nxt_idx_s;
      end else if ((state_r == ST_ACCESS) && we_r && (idx_r == pf_idx_r)) begin
        pf_valid_r <= 1'b0;
      end
    end
  end

  // Bus response registers.
  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      ack_r     <= 1'b0;
      irq_r     <= 1'b0;
      dat_ram_r <= 1'b0;
      dat_r     <= 32'h0;
    end else begin
      ack_r     <= (state_nxt_s == ST_ACK);
      irq_r     <= (state_r == ST_IDLE) && req_s && !win_s;
      dat_ram_r <= (state_r == ST_ACCESS) && req_s && !we_r;
      if (state_r == ST_IDLE && req_s && !win_s) begin
        dat_r <= 32'h0;
      end else if (state_r == ST_IDLE && req_s && !wbs_we_i && hit_s) begin
        dat_r <= hit_data_s;
      end else if (state_r == ST_ACCESS) begin
        dat_r <= 32'h0;
      end
    end
  end

  assign wbs_ack_o = ack_r;
  assign irq_oor_o = irq_r;
  // RAM reads return straight from the RAM output register to avoid an extra cycle.
  assign wbs_dat_o = dat_ram_r ? ram_dout_s : dat_r;

  wb_sram_sp #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk  (wb_clk_i),
    .en   (ram_en_s),
    .we   (ram_we_s),
    .addr (ram_addr_s),
    .din  (wdat_r),
    .dout (ram_dout_s)
  );

endmodule

// File: tb/tb_wb_bram_wait_ctrl.sv
// Scoreboard bench for wb_bram_wait_ctrl: stimulus predicts data/latency/irq from a
// word-array model with a one-entry prefetch rule; a monitor checks every acknowledge.
module tb_wb_bram_wait_ctrl;

  localparam int          DEPTH    = 1024;
  localparam logic [31:0] BASE     = 32'h3800_0000;
  localparam int          DEF_WAIT = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] wdat = 32'h0, adr = 32'h0;
  logic        ack, irq;
  logic [31:0] rdat;
  logic        ovr = 1'b0;
  logic [3:0]  cwait = 4'h0;

  wb_bram_wait_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rstn_i (rst_n),
    .wbs_stb_i (stb),
    .wbs_cyc_i (cyc),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_dat_i (wdat),
    .wbs_adr_i (adr),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .cfg_ovr_i (ovr),
    .cfg_wait_i(cwait),
    .irq_oor_o (irq)
  );

  always #5 clk = ~clk;

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] dat;
    logic        chk_dat;
    logic        irq;
    int          issue;
    int          lat;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ref_mem [DEPTH];
  bit          pf_v = 1'b0;
  int          pf_i = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, tick);
  endfunction

  // Monitor: every acknowledge must match the oldest prediction; irq only rides on acks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("latency", 32'(tick - e.issue), 32'(e.lat));
          chk("irq_on_ack", {31'd0, irq}, {31'd0, e.irq});
          if (e.chk_dat) chk("read_data", rdat, e.dat);
        end
      end else begin
        chk("irq_idle", {31'd0, irq}, 32'd0);
      end
    end
  end

  // One complete transfer: predict, issue, wait for ack (bounded), release the bus.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic o, input logic [3:0] wt);
    exp_t e;
    bit   inw, got;
    int   idx, wc;
    @(posedge clk); #1;
    inw = (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
    idx = int'((a - BASE) >> 2);
    wc  = o ? int'(wt) : DEF_WAIT;
    e.dat = 32'h0; e.chk_dat = 1'b1; e.irq = 1'b0; e.issue = tick;
    if (!inw) begin
      e.lat = 1; e.irq = 1'b1;
    end else if (!w && pf_v && idx == pf_i) begin
      e.lat = 1; e.dat = ref_mem[idx];
    end else begin
      e.lat = wc + 2;
      if (w) begin
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        e.chk_dat = 1'b0;
        if (pf_v && pf_i == idx) pf_v = 1'b0;
      end else begin
        e.dat = ref_mem[idx];
        if (idx != DEPTH - 1) begin pf_v = 1'b1; pf_i = idx + 1; end
      end
    end
    sb.push_back(e);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; wdat = d; ovr = o; cwait = wt;
    @(posedge clk); #1;
    ovr = 1'($urandom_range(0, 1)); cwait = 4'($urandom_range(0, 15));
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ack === 1'b1) got = 1'b1;
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
    repeat ($urandom_range(1, 3)) @(posedge clk);
  endtask

  // Request dropped at wait cycle 5 of a default-wait transfer: no ack, no RAM change.
  task automatic abort_wait(input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = 4'hF; wdat = d; ovr = 1'b0;
    repeat (5) @(posedge clk);
    #1; stb = 1'b0; cyc = 1'b0; we = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  // Reset asserted in the middle of a wait: outputs drop at once, prefetch is lost.
  task automatic reset_mid_wait(input logic [31:0] a);
    @(posedge clk); #1;
    stb = 1'b1; cyc = 1'b1; we = 1'b0; adr = a; sel = 4'hF; ovr = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_dat", rdat, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    stb = 1'b0; cyc = 1'b0;
    pf_v = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #600_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          last_idx, idx, r;
    logic [31:0] a;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;

    repeat (2) @(negedge clk);
    chk("reset_ack", {31'd0, ack}, 32'd0);
    chk("reset_dat", rdat, 32'd0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    @(posedge clk); #1; rst_n = 1'b1;

    for (int i = 0; i <= 16; i++)
      xfer(1'b1, BASE + 32'(4 * i), 4'hF, $urandom, 1'b1, 4'($urandom_range(0, 3)));
    xfer(1'b1, BASE + 32'(4 * 1022), 4'hF, $urandom, 1'b1, 4'd1);
    xfer(1'b1, BASE + 32'(4 * 1023), 4'hF, $urandom, 1'b1, 4'd1);

    xfer(1'b1, 32'h3800_0010, 4'hF, 32'hA5A5_0001, 1'b0, 4'd0);
    xfer(1'b0, 32'h3800_0010, 4'hF, 32'h0, 1'b0, 4'd0);
    xfer(1'b1, 32'h3800_0014, 4'hF, 32'h1122_3344, 1'b1, 4'd2);
    xfer(1'b1, 32'h3800_0014, 4'b0101, 32'hFFFF_FFFF, 1'b1, 4'd2);
    xfer(1'b0, 32'h3800_0014, 4'hF, 32'h0, 1'b1, 4'd2);
    xfer(1'b0, 32'h3800_0024, 4'hF, 32'h0, 1'b1, 4'd0);
    xfer(1'b0, 32'h3800_0030, 4'hF, 32'h0, 1'b1, 4'd15);
    xfer(1'b0, 32'h3800_0000, 4'hF, 32'h0, 1'b1, 4'd3);
    xfer(1'b0, 32'h3800_0004, 4'hF, 32'h0, 1'b1, 4'd3);
    xfer(1'b1, 32'h3800_0008, 4'hF, 32'hDEAD_BEEF, 1'b1, 4'd1);
    xfer(1'b0, 32'h3800_0008, 4'hF, 32'h0, 1'b1, 4'd1);
    xfer(1'b0, 32'h3000_0000, 4'hF, 32'h0, 1'b1, 4'd1);
    xfer(1'b1, 32'h3000_0010, 4'hF, 32'h0BAD_0BAD, 1'b1, 4'd1);
    xfer(1'b0, 32'h3800_0010, 4'hF, 32'h0, 1'b1, 4'd1);
    xfer(1'b0, 32'h3800_0FFC, 4'hF, 32'h0, 1'b1, 4'd0);
    xfer(1'b0, 32'h3800_1000, 4'hF, 32'h0, 1'b1, 4'd0);
    xfer(1'b0, 32'h37FF_FFFC, 4'hF, 32'h0, 1'b1, 4'd0);
    abort_wait(1'b1, 32'h3800_001C, 32'h7777_7777);
    xfer(1'b0, 32'h3800_001C, 4'hF, 32'h0, 1'b1, 4'd1);
    xfer(1'b0, 32'h3800_0020, 4'hF, 32'h0, 1'b1, 4'd1);
    reset_mid_wait(32'h3800_000C);
    xfer(1'b0, 32'h3800_0024, 4'hF, 32'h0, 1'b1, 4'd1);

    last_idx = 0;
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 8) begin
        case ($urandom_range(0, 2))
          0:       a = 32'h3000_0000 + 32'($urandom_range(0, 255) * 4);
          1:       a = BASE + 32'h0000_1000;
          default: a = BASE - 32'd4;
        endcase
      end else begin
        if (r < 50) begin
          idx = (last_idx == DEPTH - 1) ? 0 : last_idx + 1;
          if (idx > 16 && idx < 1022) idx = 0;
        end else begin
          idx = int'($urandom_range(0, 17));
          if (idx == 16) idx = 1022;
          else if (idx == 17) idx = 1023;
        end
        a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
        last_idx = idx;
      end
      xfer(1'($urandom_range(0, 2) == 0), a, 4'($urandom_range(0, 15)), $urandom,
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    repeat (5) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
